// File: rtl/nvdla_glb_intr_ctrl_if.sv
// Bus bundle between the GLB interrupt controller and its CSR/unit-side driver.
interface nvdla_glb_intr_ctrl_if #(
  parameter int unsigned NUM_SRC = 12,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMR_W   = 16
);
  logic [NUM_SRC-1:0] src_pulse;
  logic               set_trigger;
  logic               clr_trigger;
  logic [NUM_SRC-1:0] wr_data;
  logic [NUM_SRC-1:0] mask;
  logic               coal_en;
  logic [CNT_W-1:0]   coal_thresh;
  logic [TMR_W-1:0]   coal_timeout;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] overflow;
  logic               core_intr;
  logic               intr_pulse;

  // Driver side: unit pulses, CSR strobes and configuration.
  modport master (
    output src_pulse, set_trigger, clr_trigger, wr_data, mask,
           coal_en, coal_thresh, coal_timeout,
    input  status, overflow, core_intr, intr_pulse
  );

  // Controller side.
  modport slave (
    input  src_pulse, set_trigger, clr_trigger, wr_data, mask,
           coal_en, coal_thresh, coal_timeout,
    output status, overflow, core_intr, intr_pulse
  );
endinterface

// File: rtl/nvdla_glb_intr_ctrl.sv
// GLB done-interrupt collector: sticky status/overflow bits plus a
// threshold/timeout coalescing FSM in front of the core interrupt line.
module nvdla_glb_intr_ctrl #(
  parameter int unsigned NUM_SRC = 12,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMR_W   = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  nvdla_glb_intr_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] status_q, status_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               core_intr_q, core_intr_d;
  logic               intr_pulse_q, intr_pulse_d;

  logic [NUM_SRC-1:0] set_v, clr_v, ovf_clr_v;
  logic               raw, new_evt, go, tmo;

  // Status/overflow update, event detection and coalescing decision.
  always_comb begin
    src_d      = bus.src_pulse;
    set_v      = {NUM_SRC{bus.set_trigger}} & bus.wr_data;
    clr_v      = {NUM_SRC{bus.clr_trigger}} & bus.wr_data;
    // A simultaneous set suppresses the clear of overflow bits.
    ovf_clr_v  = {NUM_SRC{bus.clr_trigger & ~bus.set_trigger}} & bus.wr_data;
    status_d   = (status_q & ~clr_v) | set_v | src_q;
    overflow_d = (overflow_q & ~ovf_clr_v) | (src_q & status_q);

    raw     = |(status_q & ~bus.mask);
    new_evt = |(src_q & ~bus.mask);
    go      = ~bus.coal_en | (evt_cnt_q >= bus.coal_thresh);
    tmo     = (bus.coal_timeout != '0) && (tmr_q >= bus.coal_timeout);
  end

  // Next-state, counters and registered interrupt outputs.
  always_comb begin
    state_d      = state_q;
    evt_cnt_d    = evt_cnt_q;
    tmr_d        = tmr_q;
    core_intr_d  = 1'b0;
    intr_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (raw) state_d = go ? ST_FIRE : ST_WAIT;
      end
      ST_WAIT: begin
        if (!raw)           state_d = ST_IDLE;
        else if (go || tmo) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        if (!raw) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Count unmasked event cycles; restart on every IDLE/FIRE entry.
    if ((state_d == ST_IDLE && state_q != ST_IDLE) ||
        (state_d == ST_FIRE && state_q != ST_FIRE)) begin
      evt_cnt_d = '0;
    end else if (new_evt && state_q != ST_FIRE && evt_cnt_q != '1) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end

    // Timer runs only while residing in WAIT.
    if (state_q == ST_WAIT) begin
      if (state_d != ST_WAIT)  tmr_d = '0;
      else if (tmr_q != '1)    tmr_d = tmr_q + TMR_W'(1);
    end

    core_intr_d  = (state_d == ST_FIRE);
    intr_pulse_d = (state_d == ST_FIRE) && (state_q != ST_FIRE);
  end

  // State and datapath registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      status_q     <= '0;
      overflow_q   <= '0;
      evt_cnt_q    <= '0;
      tmr_q        <= '0;
      core_intr_q  <= 1'b0;
      intr_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      status_q     <= status_d;
      overflow_q   <= overflow_d;
      evt_cnt_q    <= evt_cnt_d;
      tmr_q        <= tmr_d;
      core_intr_q  <= core_intr_d;
      intr_pulse_q <= intr_pulse_d;
    end
  end

  assign bus.status     = status_q;
  assign bus.overflow   = overflow_q;
  assign bus.core_intr  = core_intr_q;
  assign bus.intr_pulse = intr_pulse_q;

endmodule

// File: tb/tb_nvdla_glb_intr_ctrl.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs into a
// queue, and a monitor pops and compares after every rising edge.
module tb_nvdla_glb_intr_ctrl;
  localparam int unsigned NUM_SRC = 12;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TMR_W   = 16;
  localparam int ALL     = (1 << NUM_SRC) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int TMR_MAX = (1 << TMR_W) - 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nvdla_glb_intr_ctrl_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .TMR_W(TMR_W)) ifc ();

  nvdla_glb_intr_ctrl #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .TMR_W(TMR_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int status;
    int overflow;
    int core;
    int pulse;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain integers, mode 0=idle 1=waiting 2=firing.
  int m_prev_src, m_status, m_ovf, m_mode, m_cnt, m_tmr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_prev_src = 0; m_status = 0; m_ovf = 0; m_mode = 0; m_cnt = 0; m_tmr = 0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  function automatic exp_t model_step();
    exp_t e;
    int   src, wr, msk, set_bits, clr_bits, nxt, ovf_clr;
    bit   pending, fresh, ready, timed_out;
    src = int'(ifc.src_pulse);
    wr  = int'(ifc.wr_data);
    msk = int'(ifc.mask);
    set_bits = ifc.set_trigger ? wr : 0;
    clr_bits = ifc.clr_trigger ? wr : 0;
    ovf_clr  = (ifc.clr_trigger && !ifc.set_trigger) ? wr : 0;

    pending   = (m_status & ~msk & ALL) != 0;
    fresh     = (m_prev_src & ~msk & ALL) != 0;
    ready     = !ifc.coal_en || (m_cnt >= int'(ifc.coal_thresh));
    timed_out = (ifc.coal_timeout != 0) && (m_tmr >= int'(ifc.coal_timeout));

    if (!pending)                          nxt = 0;
    else if (m_mode == 2)                  nxt = 2;
    else if (ready)                        nxt = 2;
    else if (m_mode == 1 && timed_out)     nxt = 2;
    else                                   nxt = 1;

    e.core  = (nxt == 2) ? 1 : 0;
    e.pulse = (nxt == 2 && m_mode != 2) ? 1 : 0;

    if ((nxt == 0 && m_mode != 0) || (nxt == 2 && m_mode != 2)) m_cnt = 0;
    else if (fresh && m_mode != 2 && m_cnt < CNT_MAX)          m_cnt = m_cnt + 1;

    if (m_mode == 1) m_tmr = (nxt == 1) ? ((m_tmr < TMR_MAX) ? m_tmr + 1 : m_tmr) : 0;

    m_ovf      = ((m_ovf & ~ovf_clr) | (m_prev_src & m_status)) & ALL;
    m_status   = ((m_status & ~clr_bits) | set_bits | m_prev_src) & ALL;
    m_mode     = nxt;
    m_prev_src = src;
    e.status   = m_status;
    e.overflow = m_ovf;
    return e;
  endfunction

  // Monitor: compare DUT outputs with the oldest prediction after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("status",     int'(ifc.status),     e.status);
      chk("overflow",   int'(ifc.overflow),   e.overflow);
      chk("core_intr",  int'(ifc.core_intr),  e.core);
      chk("intr_pulse", int'(ifc.intr_pulse), e.pulse);
    end
  end

  task automatic clear_inputs();
    ifc.src_pulse = '0; ifc.set_trigger = 1'b0; ifc.clr_trigger = 1'b0;
    ifc.wr_data = '0;   ifc.mask = '0;          ifc.coal_en = 1'b0;
    ifc.coal_thresh = '0; ifc.coal_timeout = '0;
  endtask

  // One clock: predict, let the edge happen, return just after the monitor.
  task automatic tick();
    exp_q.push_back(model_step());
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_src(input int bits);
    ifc.src_pulse = NUM_SRC'(bits);
    tick();
    ifc.src_pulse = '0;
  endtask

  // Assert reset away from the edge and check outputs clear immediately.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_status",    int'(ifc.status),     0);
    chk("rst_overflow",  int'(ifc.overflow),   0);
    chk("rst_core_intr", int'(ifc.core_intr),  0);
    chk("rst_pulse",     int'(ifc.intr_pulse), 0);
    exp_q.delete();
    model_reset();
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Basic path, no coalescing.
    pulse_src('h001);
    tick();
    chk("t1_status_c2", int'(ifc.status), 'h001);
    tick();
    chk("t1_core_c3", int'(ifc.core_intr), 1);
    chk("t1_pulse_c3", int'(ifc.intr_pulse), 1);
    ifc.clr_trigger = 1'b1; ifc.wr_data = NUM_SRC'('h001);
    tick();
    ifc.clr_trigger = 1'b0; ifc.wr_data = '0;
    chk("t1_status_clr", int'(ifc.status), 0);
    tick();
    chk("t1_core_clr", int'(ifc.core_intr), 0);

    // Overflow on a repeated source.
    pulse_src('h020);
    repeat (2) tick();
    pulse_src('h020);
    repeat (2) tick();
    chk("t2_overflow5", int'(ifc.overflow[5]), 1);
    ifc.clr_trigger = 1'b1; ifc.wr_data = NUM_SRC'('h020);
    tick();
    ifc.clr_trigger = 1'b0; ifc.wr_data = '0;
    chk("t2_status5_clr", int'(ifc.status[5]), 0);
    chk("t2_ovf5_clr", int'(ifc.overflow[5]), 0);
    repeat (2) tick();

    // Threshold coalescing: three events, fire in cycle 11.
    do_reset();
    ifc.coal_en = 1'b1; ifc.coal_thresh = CNT_W'(3); ifc.coal_timeout = '0;
    for (int c = 0; c < 12; c++) begin
      ifc.src_pulse = (c == 0) ? NUM_SRC'('h002) : (c == 4) ? NUM_SRC'('h004) :
                      (c == 8) ? NUM_SRC'('h008) : NUM_SRC'(0);
      tick();
      if (c + 1 == 10) chk("t3_core_c10", int'(ifc.core_intr), 0);
      if (c + 1 == 11) begin
        chk("t3_core_c11", int'(ifc.core_intr), 1);
        chk("t3_pulse_c11", int'(ifc.intr_pulse), 1);
      end
    end
    ifc.src_pulse = '0;

    // Timeout coalescing: WAIT from cycle 3, fire in cycle 14.
    do_reset();
    ifc.coal_en = 1'b1; ifc.coal_thresh = CNT_W'(4); ifc.coal_timeout = TMR_W'(10);
    for (int c = 0; c < 15; c++) begin
      ifc.src_pulse = (c == 0) ? NUM_SRC'('h001) : NUM_SRC'(0);
      tick();
      if (c + 1 == 13) chk("t4_core_c13", int'(ifc.core_intr), 0);
      if (c + 1 == 14) chk("t4_core_c14", int'(ifc.core_intr), 1);
    end

    // Simultaneous set and clear, then mask everything while firing.
    do_reset();
    ifc.set_trigger = 1'b1; ifc.clr_trigger = 1'b1; ifc.wr_data = NUM_SRC'('h00F);
    tick();
    ifc.set_trigger = 1'b0; ifc.clr_trigger = 1'b0; ifc.wr_data = '0;
    chk("t5_status", int'(ifc.status), 'h00F);
    tick();
    chk("t5_core", int'(ifc.core_intr), 1);
    ifc.mask = NUM_SRC'(ALL);
    tick();
    chk("t5_core_masked", int'(ifc.core_intr), 0);
    chk("t5_status_kept", int'(ifc.status), 'h00F);
    ifc.mask = '0;
    repeat (3) tick();

    // Reset while waiting with two counted events, then stay quiet.
    do_reset();
    ifc.coal_en = 1'b1; ifc.coal_thresh = CNT_W'(4);
    pulse_src('h001);
    pulse_src('h002);
    repeat (3) tick();
    do_reset();
    ifc.coal_en = 1'b1; ifc.coal_thresh = CNT_W'(4);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t6_quiet", int'(ifc.core_intr), 0);
    end

    // Randomized traffic with periodic reconfiguration and rare resets.
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) begin
        ifc.coal_en      = 1'($urandom_range(0, 1));
        ifc.coal_thresh  = CNT_W'($urandom_range(0, 5));
        ifc.coal_timeout = TMR_W'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        ifc.coal_en      = 1'($urandom_range(0, 1));
        ifc.coal_thresh  = CNT_W'($urandom_range(0, 5));
        ifc.coal_timeout = TMR_W'($urandom_range(0, 12));
      end
      ifc.src_pulse   = NUM_SRC'($urandom & $urandom & $urandom & $urandom);
      ifc.set_trigger = ($urandom_range(0, 19) == 0);
      ifc.clr_trigger = ($urandom_range(0, 5) == 0);
      ifc.wr_data     = NUM_SRC'($urandom);
      if ($urandom_range(0, 15) == 0) ifc.mask = NUM_SRC'($urandom & $urandom);
      tick();
    end
    clear_inputs();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
